aes_round_ctrl: RTL and testbench

- Sequences one AES-128 encryption across the per-stage datapath blocks: round-key generator, SubBytes, ShiftRows, MixColumns and AddRoundKey.
- Every stage uses the same handshake: an enable input and a registered success output.
- Issues one stage enable at a time, waits for that stage's success, pulses a state-register load with a source select, and steps the round counter.
- Sits between the top-level start/done interface and the stage modules.

---
 rtl/aes_ctrl_pkg.sv | 49 ++++
 rtl/aes_step_watchdog.sv | 33 +++
 rtl/aes_round_ctrl.sv | 156 +++++++++++++++
 tb/tb_aes_round_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-128 round controller.
package aes_ctrl_pkg;

  localparam int NR_AES128 = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KX,
    S_SB,
    S_SR,
    S_MC,
    S_ARK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] SRC_SB  = 2'd0;
  localparam logic [1:0] SRC_SR  = 2'd1;
  localparam logic [1:0] SRC_MC  = 2'd2;
  localparam logic [1:0] SRC_ARK = 2'd3;

  typedef struct packed {
    logic kx;
    logic sb;
    logic sr;
    logic mc;
    logic ark;
  } stage_en_t;

  // One-hot stage enable for a given FSM state; all zero outside step states.
  function automatic stage_en_t step_enables(input state_t s);
    stage_en_t e;
    e = '0;
    case (s)
      S_KX:    e.kx  = 1'b1;
      S_SB:    e.sb  = 1'b1;
      S_SR:    e.sr  = 1'b1;
      S_MC:    e.mc  = 1'b1;
      S_ARK:   e.ark = 1'b1;
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic logic is_step(input state_t s);
    return (s inside {S_KX, S_SB, S_SR, S_MC, S_ARK});
  endfunction

endpackage

// File: rtl/aes_step_watchdog.sv
// Per-step watchdog: counts cycles spent in the current step and flags the
// last allowed cycle so the controller can bail out to its error state.
module aes_step_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Cycle counter; cleared on every step change, saturates on the last cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count_en && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // cnt holds the number of cycles already spent, so LAST marks the
  // TIMEOUT-th cycle in the step.
  assign expire = count_en && (cnt == LAST);

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: walks KX/SB/SR/MC/ARK steps per round, issues one
// stage enable at a time and pulses the state-register load on completion.
//
// state  | meaning
// IDLE   | waiting for start
// KX     | round-key generator enabled
// SB     | SubBytes enabled
// SR     | ShiftRows enabled
// MC     | MixColumns enabled (skipped in final round)
// ARK    | AddRoundKey enabled; round advances on completion
// DONE   | one-cycle completion pulse
// ERR    | watchdog expired; left only by start
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NR      = NR_AES128,
  parameter int RW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          kx_success,
  input  logic          sb_success,
  input  logic          sr_success,
  input  logic          mc_success,
  input  logic          ark_success,
  output logic          kx_en,
  output logic          sb_en,
  output logic          sr_en,
  output logic          mc_en,
  output logic          ark_en,
  output logic [RW-1:0] round,
  output logic          state_load,
  output logic [1:0]    src_sel,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam logic [RW-1:0] NR_R = RW'(NR);

  state_t        state;
  state_t        nxt;
  logic [RW-1:0] nxt_round;
  logic          nxt_load;
  logic [1:0]    nxt_src;
  stage_en_t     en_q;
  logic          expire;
  logic          wd_clear;

  aes_step_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (wd_clear),
    .count_en (is_step(state)),
    .expire   (expire)
  );

  // Restart the watchdog on every step change and outside step states.
  assign wd_clear = (nxt != state) || !is_step(state);

  // Next-state and next-output decode.
  always_comb begin
    nxt       = state;
    nxt_round = round;
    nxt_load  = 1'b0;
    nxt_src   = src_sel;
    case (state)
      S_IDLE, S_ERR: begin
        if (start && !abort) begin
          nxt       = S_KX;
          nxt_round = '0;
        end
      end
      S_KX: begin
        if (kx_success) nxt = (round == '0) ? S_ARK : S_SB;
      end
      S_SB: begin
        if (sb_success) begin
          nxt      = S_SR;
          nxt_load = 1'b1;
          nxt_src  = SRC_SB;
        end
      end
      S_SR: begin
        if (sr_success) begin
          nxt      = (round == NR_R) ? S_ARK : S_MC;
          nxt_load = 1'b1;
          nxt_src  = SRC_SR;
        end
      end
      S_MC: begin
        if (mc_success) begin
          nxt      = S_ARK;
          nxt_load = 1'b1;
          nxt_src  = SRC_MC;
        end
      end
      S_ARK: begin
        if (ark_success) begin
          nxt_load = 1'b1;
          nxt_src  = SRC_ARK;
          if (round == NR_R) begin
            nxt = S_DONE;
          end else begin
            nxt       = S_KX;
            nxt_round = round + RW'(1);
          end
        end
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    // A success on the expiring cycle already moved us on, so only a stalled
    // step times out.
    if (is_step(state) && (nxt == state) && expire) nxt = S_ERR;
    if (abort && is_step(state)) begin
      nxt       = S_IDLE;
      nxt_round = '0;
      nxt_load  = 1'b0;
      nxt_src   = src_sel;
    end
  end

  // State and registered outputs, all derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      en_q       <= '0;
      round      <= '0;
      state_load <= 1'b0;
      src_sel    <= SRC_SB;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= nxt;
      en_q       <= step_enables(nxt);
      round      <= nxt_round;
      state_load <= nxt_load;
      src_sel    <= nxt_src;
      busy       <= is_step(nxt);
      done       <= (nxt == S_DONE);
      error      <= (nxt == S_ERR);
    end
  end

  assign kx_en  = en_q.kx;
  assign sb_en  = en_q.sb;
  assign sr_en  = en_q.sr;
  assign mc_en  = en_q.mc;
  assign ark_en = en_q.ark;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with behavioural single-cycle stage models.
module tb_aes_round_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] succ_v;
  logic       kx_en, sb_en, sr_en, mc_en, ark_en;
  logic [3:0] round;
  logic       state_load;
  logic [1:0] src_sel;
  logic       busy, done, error;
  logic [4:0] en_v;
  logic [14:0] outs;

  int checks = 0;
  int errors = 0;

  // stage model knobs: SB slow in one round, MC stuck in one round (-1 = off)
  int sb_slow_round = -1;
  int mc_hang_round = -1;
  int cnt [5];

  // results of the last run_once
  logic [4:0] q_en[$];
  logic [1:0] q_src[$];
  logic [4:0] exp_en[$];
  logic [1:0] exp_src[$];
  int done_cyc, err_cyc, first_mc, mc_cnt, sb_max, busy_cnt, onehot_bad, err_c1;

  always #5 clk = ~clk;

  aes_round_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .kx_success  (succ_v[4]),
    .sb_success  (succ_v[3]),
    .sr_success  (succ_v[2]),
    .mc_success  (succ_v[1]),
    .ark_success (succ_v[0]),
    .kx_en       (kx_en),
    .sb_en       (sb_en),
    .sr_en       (sr_en),
    .mc_en       (mc_en),
    .ark_en      (ark_en),
    .round       (round),
    .state_load  (state_load),
    .src_sel     (src_sel),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  assign en_v = {kx_en, sb_en, sr_en, mc_en, ark_en};
  assign outs = {en_v, state_load, busy, done, error, src_sel, round};

  function automatic int lat_of(input int i);
    if (i == 3 && sb_slow_round >= 0 && int'(round) == sb_slow_round) return 5;
    if (i == 1 && mc_hang_round >= 0 && int'(round) == mc_hang_round) return 100000;
    return 1;
  endfunction

  // Stage models: registered success lat cycles after the enable rises.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      succ_v <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= 0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (!en_v[i] || succ_v[i]) begin
          succ_v[i] <= 1'b0;
          cnt[i]    <= 0;
        end else if (cnt[i] >= lat_of(i) - 1) begin
          succ_v[i] <= 1'b1;
          cnt[i]    <= 0;
        end else begin
          cnt[i] <= cnt[i] + 1;
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic build_expected();
    exp_en.delete();
    exp_src.delete();
    exp_en.push_back(5'b10000); exp_en.push_back(5'b00001);
    exp_src.push_back(2'd3);
    for (int r = 1; r <= 9; r++) begin
      exp_en.push_back(5'b10000); exp_en.push_back(5'b01000);
      exp_en.push_back(5'b00100); exp_en.push_back(5'b00010);
      exp_en.push_back(5'b00001);
      exp_src.push_back(2'd0); exp_src.push_back(2'd1);
      exp_src.push_back(2'd2); exp_src.push_back(2'd3);
    end
    exp_en.push_back(5'b10000); exp_en.push_back(5'b01000);
    exp_en.push_back(5'b00100); exp_en.push_back(5'b00001);
    exp_src.push_back(2'd0); exp_src.push_back(2'd1); exp_src.push_back(2'd3);
  endtask

  // Pulse start (sampled at end of cycle 0), then observe cycles 1..budget
  // until done or error.
  task automatic run_once(input int budget, input bit poke_start);
    logic [4:0] prev;
    int sb_run;
    q_en.delete();
    q_src.delete();
    done_cyc = -1; err_cyc = -1; first_mc = -1; mc_cnt = 0; sb_max = 0;
    busy_cnt = 0; onehot_bad = 0; err_c1 = -1;
    prev = '0; sb_run = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= budget; k++) begin
      if (k > 1) @(negedge clk);
      start = poke_start && (k == 10 || k == 40 || k == 80);
      if (k == 1) err_c1 = int'(error);
      if ($countones(en_v) > 1) onehot_bad++;
      if (en_v != 5'b0 && en_v != prev) begin
        q_en.push_back(en_v);
        if (mc_en) begin
          mc_cnt++;
          if (first_mc < 0) first_mc = k;
        end
      end
      prev = en_v;
      if (sb_en) sb_run++; else sb_run = 0;
      if (sb_run > sb_max) sb_max = sb_run;
      if (state_load) q_src.push_back(src_sel);
      if (busy) busy_cnt++;
      if (done && done_cyc < 0) done_cyc = k;
      if (error && err_cyc < 0) err_cyc = k;
      if (done_cyc >= 0 || err_cyc >= 0) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (outs !== 15'd0) begin
      errors++; $display("FAIL reset_during: outs=%h want 0", outs);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 15'd0) begin
      errors++; $display("FAIL reset_after: outs=%h want 0", outs);
    end
  endtask

  task automatic test_full_run();
    int bad;
    run_once(300, 1'b0);
    checks++;
    if (done_cyc !== 103) begin
      errors++; $display("FAIL full_done_cycle: got %0d want 103", done_cyc);
    end
    checks++;
    if (round !== 4'd10) begin
      errors++; $display("FAIL full_round_end: got %0d want 10", round);
    end
    checks++;
    if (q_en.size() !== 51) begin
      errors++; $display("FAIL full_step_count: got %0d want 51", q_en.size());
    end
    bad = 0;
    for (int i = 0; i < q_en.size() && i < exp_en.size(); i++)
      if (q_en[i] !== exp_en[i]) bad++;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL full_enable_order: %0d wrong steps want 0", bad);
    end
    checks++;
    if (mc_cnt !== 9) begin
      errors++; $display("FAIL full_mc_count: got %0d want 9", mc_cnt);
    end
    checks++;
    if (q_src.size() !== 40) begin
      errors++; $display("FAIL full_load_count: got %0d want 40", q_src.size());
    end
    bad = 0;
    for (int i = 0; i < q_src.size() && i < exp_src.size(); i++)
      if (q_src[i] !== exp_src[i]) bad++;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL full_src_sel: %0d wrong loads want 0", bad);
    end
    checks++;
    if (onehot_bad !== 0) begin
      errors++; $display("FAIL full_onehot: %0d multi-enable cycles want 0", onehot_bad);
    end
    checks++;
    if (busy_cnt !== 102) begin
      errors++; $display("FAIL full_busy_cycles: got %0d want 102", busy_cnt);
    end
    checks++;
    if (sb_max !== 2) begin
      errors++; $display("FAIL full_sb_hold: got %0d want 2", sb_max);
    end
    checks++;
    if ({busy, error} !== 2'b00) begin
      errors++; $display("FAIL full_done_flags: busy,error=%b want 00", {busy, error});
    end
    @(negedge clk);
    checks++;
    if ({done, state_load, busy, round} !== {3'b000, 4'd10}) begin
      errors++; $display("FAIL full_after_done: done=%b load=%b busy=%b round=%0d want 0 0 0 10",
                         done, state_load, busy, round);
    end
  endtask

  task automatic test_sb_delay();
    sb_slow_round = 3;
    run_once(300, 1'b0);
    sb_slow_round = -1;
    checks++;
    if (done_cyc !== 107) begin
      errors++; $display("FAIL sbdly_done_cycle: got %0d want 107", done_cyc);
    end
    checks++;
    if (sb_max !== 6) begin
      errors++; $display("FAIL sbdly_sb_hold: got %0d want 6", sb_max);
    end
    checks++;
    if (err_cyc !== -1) begin
      errors++; $display("FAIL sbdly_error: error cycle %0d want none", err_cyc);
    end
  endtask

  task automatic test_timeout();
    int drops;
    mc_hang_round = 1;
    run_once(400, 1'b0);
    checks++;
    if (err_cyc - first_mc !== 64) begin
      errors++; $display("FAIL tmo_latency: got %0d want 64 (mc at %0d err at %0d)",
                         err_cyc - first_mc, first_mc, err_cyc);
    end
    checks++;
    if ({error, busy, en_v, done} !== {1'b1, 1'b0, 5'b0, 1'b0}) begin
      errors++; $display("FAIL tmo_outputs: error=%b busy=%b en=%b done=%b want 1 0 00000 0",
                         error, busy, en_v, done);
    end
    drops = 0;
    repeat (5) begin
      @(negedge clk);
      if (error !== 1'b1 || busy !== 1'b0) drops++;
    end
    checks++;
    if (drops !== 0) begin
      errors++; $display("FAIL tmo_sticky: %0d cycles without error want 0", drops);
    end
    mc_hang_round = -1;
    run_once(300, 1'b0);
    checks++;
    if (err_c1 !== 0) begin
      errors++; $display("FAIL tmo_restart_clear: error=%0d in cycle 1 want 0", err_c1);
    end
    checks++;
    if (done_cyc !== 103) begin
      errors++; $display("FAIL tmo_restart_done: got %0d want 103", done_cyc);
    end
  endtask

  task automatic test_abort();
    bit found;
    int bad;
    found = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (sr_en && round == 4'd5) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (found !== 1'b1) begin
      errors++; $display("FAIL abort_reach_sr5: found=%0d want 1", found);
    end
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({en_v, busy, done, state_load, round} !== 12'd0) begin
      errors++; $display("FAIL abort_next_cycle: en=%b busy=%b done=%b load=%b round=%0d want all 0",
                         en_v, busy, done, state_load, round);
    end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || state_load || busy) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL abort_quiet: %0d active cycles want 0", bad);
    end
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    bad = 0;
    repeat (5) begin
      if (busy || en_v != 5'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL abort_start_same: %0d busy cycles want 0", bad);
    end
  endtask

  task automatic test_reset_mid_run();
    bit found;
    int bad;
    found = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (ark_en && round == 4'd7) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (found !== 1'b1) begin
      errors++; $display("FAIL rst_reach_ark7: found=%0d want 1", found);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (outs !== 15'd0) begin
      errors++; $display("FAIL rst_mid_immediate: outs=%h want 0", outs);
    end
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy || round != 4'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL rst_mid_quiet: %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_start_while_busy();
    int bad;
    run_once(300, 1'b1);
    checks++;
    if (done_cyc !== 103) begin
      errors++; $display("FAIL busy_start_done: got %0d want 103", done_cyc);
    end
    bad = 0;
    for (int i = 0; i < q_en.size() && i < exp_en.size(); i++)
      if (q_en[i] !== exp_en[i]) bad++;
    checks++;
    if (q_en.size() !== 51 || bad !== 0) begin
      errors++; $display("FAIL busy_start_order: %0d steps, %0d wrong want 51, 0", q_en.size(), bad);
    end
    checks++;
    if (q_src.size() !== 40) begin
      errors++; $display("FAIL busy_start_loads: got %0d want 40", q_src.size());
    end
  endtask

  initial begin
    build_expected();
    test_reset();
    test_full_run();
    test_sb_delay();
    test_timeout();
    test_abort();
    test_reset_mid_run();
    test_start_while_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
